// File: rtl/mux8to1_rr.sv
// Registered 8-to-1 round-robin arbitrating multiplexer with valid/ready on
// every channel and a one-entry output register tagged with the source index.
module mux8to1_rr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] In0,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [WIDTH-1:0] In3,
   input  logic [WIDTH-1:0] In4,
   input  logic [WIDTH-1:0] In5,
   input  logic [WIDTH-1:0] In6,
   input  logic [WIDTH-1:0] In7,
   input  logic [7:0]       InValid,
   output logic [7:0]       InReady,
   output logic [WIDTH-1:0] Out,
   output logic [2:0]       OutSel,
   output logic             OutValid,
   input  logic             OutReady
);

   logic [WIDTH-1:0] in_arr [8];
   logic [WIDTH-1:0] out_q, out_d;
   logic [2:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [2:0]       ptr_q, ptr_d;

   logic [15:0]      valid_dbl;
   logic [7:0]       valid_rot;
   logic [2:0]       offset;
   logic [2:0]       grant;
   logic             any_valid;
   logic             load;
   logic             take;

   assign in_arr[0] = In0;
   assign in_arr[1] = In1;
   assign in_arr[2] = In2;
   assign in_arr[3] = In3;
   assign in_arr[4] = In4;
   assign in_arr[5] = In5;
   assign in_arr[6] = In6;
   assign in_arr[7] = In7;

   // Rotate the request vector so bit 0 is the current highest-priority channel.
   assign valid_dbl = {InValid, InValid};
   assign valid_rot = valid_dbl[ptr_q +: 8];

   always_comb begin
      offset = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (valid_rot[k]) begin
            offset = 3'(k);
         end
      end
   end

   assign grant     = ptr_q + offset;
   assign any_valid = |InValid;
   assign load      = ~valid_q | OutReady;
   // Gate with rst_n so no handshake can complete while reset is held.
   assign take      = load & any_valid & rst_n;

   always_comb begin
      InReady = 8'd0;
      if (take) begin
         InReady = 8'd1 << grant;
      end
   end

   always_comb begin
      out_d   = out_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (load) begin
         if (any_valid) begin
            out_d   = in_arr[grant];
            sel_d   = grant;
            valid_d = 1'b1;
            ptr_d   = grant + 3'd1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         sel_q   <= 3'd0;
         valid_q <= 1'b0;
         ptr_q   <= 3'd0;
      end else begin
         out_q   <= out_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign Out      = out_q;
   assign OutSel   = sel_q;
   assign OutValid = valid_q;

endmodule
